// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-stage access unit:
//   - Size field encodings (byte / reserved / word / double)
//   - FSM state type for the two-cycle double access
//   - width of the write-back control bundle
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_RSVD   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    localparam int unsigned WB_CTRL_W = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_e;

    // Sign-extend a loaded byte to a full register word.
    function automatic logic [31:0] sext_byte(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the EX/MEM request side and the MEM_WB result side of the memory
// access unit.
//   master : pipeline side (drives requests, receives results)
//   slave  : mem_access_unit (receives requests, drives results)
// Signals:
//   MemRead, MemWrite, Size[1:0], Adrs[31:0], WrData[31:0], WrData64[63:0],
//   WB_control_EX[9:0]                    -- request / control in
//   OUT_data_MEM[31:0], OUT_data64_MEM[63:0], WB_control_MEM[9:0],
//   Stall, Fault                          -- results out
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
    import mem_pkg::*;

    logic                 MemRead;
    logic                 MemWrite;
    logic [1:0]           Size;
    logic [31:0]          Adrs;
    logic [31:0]          WrData;
    logic [63:0]          WrData64;
    logic [WB_CTRL_W-1:0] WB_control_EX;

    logic [31:0]          OUT_data_MEM;
    logic [63:0]          OUT_data64_MEM;
    logic [WB_CTRL_W-1:0] WB_control_MEM;
    logic                 Stall;
    logic                 Fault;

    modport master (
        output MemRead, MemWrite, Size, Adrs, WrData, WrData64, WB_control_EX,
        input  OUT_data_MEM, OUT_data64_MEM, WB_control_MEM, Stall, Fault
    );

    modport slave (
        input  MemRead, MemWrite, Size, Adrs, WrData, WrData64, WB_control_EX,
        output OUT_data_MEM, OUT_data64_MEM, WB_control_MEM, Stall, Fault
    );

endinterface

// File: rtl/data_ram.sv
// -----------------------------------------------------------------------------
// data_ram
// DEPTH x 32-bit word-organised data memory.
// Ports:
//   Clk        clock, writes on rising edge
//   Rst_n      synchronous active-low reset; suppresses writes (contents kept)
//   raddr_i    combinational read word index
//   rdata_o    read data
//   we_i       write enable
//   be_i[3:0]  byte enables, bit n covers wdata_i[8n+7:8n]
//   waddr_i    write word index
//   wdata_i    write data
// -----------------------------------------------------------------------------
module data_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i
);

    logic [31:0] mem_q [DEPTH];

    assign rdata_o = mem_q[raddr_i];

    always_ff @(posedge Clk) begin
        if (Rst_n && we_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage data access unit (EX/MEM -> MEM_WB). Byte, word and 64-bit
// loads/stores against an internal 32-bit wide RAM. Doubles take two cycles:
// the first cycle stalls upstream and bubbles the write-back controls.
// Ports:
//   Clk    single clock
//   Rst_n  synchronous active-low reset; forces all outputs to 0
//   bus    mem_access_unit_if.slave (requests in, results/Stall/Fault out)
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                Clk,
    input  logic                Rst_n,
    mem_access_unit_if.slave    bus
);

    state_e      state_q, state_d;
    logic [31:0] lo_hold_q, lo_hold_d;

    logic          req;
    logic          illegal;
    logic          fault;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;
    logic [AW-1:0] ram_addr;
    logic [31:0]   rdata;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [1:0]    lane;
    logic [7:0]    lane_byte;

    logic [31:0]          out_data;
    logic [63:0]          out_data64;
    logic [WB_CTRL_W-1:0] wb_ctrl;
    logic                 stall;

    // Address bits above the word index only alias; they are intentionally ignored.
    logic unused_adrs_hi;
    assign unused_adrs_hi = ^bus.Adrs[31:AW+2];

    assign idx     = bus.Adrs[AW+1:2];
    assign idx_nxt = idx + AW'(1);
    assign lane    = bus.Adrs[1:0];

    // Alignment / legality check, purely combinational.
    always_comb begin
        req     = bus.MemRead | bus.MemWrite;
        illegal = (bus.MemRead & bus.MemWrite)
                | (bus.Size == SZ_RSVD)
                | ((bus.Size == SZ_WORD)   & (bus.Adrs[1:0] != 2'b00))
                | ((bus.Size == SZ_DOUBLE) & (bus.Adrs[2:0] != 3'b000));
        fault   = Rst_n & req & illegal;
    end

    data_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .raddr_i (ram_addr),
        .rdata_o (rdata),
        .we_i    (we),
        .be_i    (be),
        .waddr_i (ram_addr),
        .wdata_i (wdata)
    );

    assign lane_byte = rdata[{lane, 3'b000} +: 8];

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            lo_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            lo_hold_q <= lo_hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lo_hold_d  = lo_hold_q;
        ram_addr   = idx;
        we         = 1'b0;
        be         = '0;
        wdata      = '0;
        out_data   = '0;
        out_data64 = '0;
        wb_ctrl    = '0;
        stall      = 1'b0;

        if (Rst_n) begin
            if (state_q == SECOND) begin
                // Upstream is frozen, so the request still names the low word;
                // the single RAM port is steered to the high word this cycle.
                state_d  = IDLE;
                ram_addr = idx_nxt;
                if (!fault) begin
                    wb_ctrl = bus.WB_control_EX;
                    if (bus.MemRead) begin
                        out_data64 = {rdata, lo_hold_q};
                    end else if (bus.MemWrite) begin
                        we    = 1'b1;
                        be    = '1;
                        wdata = bus.WrData64[63:32];
                    end
                end
            end else if (!fault) begin
                if (req && (bus.Size == SZ_DOUBLE)) begin
                    stall   = 1'b1;
                    state_d = SECOND;
                    if (bus.MemRead) begin
                        lo_hold_d = rdata;
                    end else begin
                        we    = 1'b1;
                        be    = '1;
                        wdata = bus.WrData64[31:0];
                    end
                end else begin
                    wb_ctrl = bus.WB_control_EX;
                    if (bus.MemRead) begin
                        out_data = (bus.Size == SZ_BYTE) ? sext_byte(lane_byte) : rdata;
                    end else if (bus.MemWrite) begin
                        we = 1'b1;
                        if (bus.Size == SZ_BYTE) begin
                            be    = 4'b0001 << lane;
                            wdata = {4{bus.WrData[7:0]}};
                        end else begin
                            be    = '1;
                            wdata = bus.WrData;
                        end
                    end
                end
            end
        end
    end

    assign bus.OUT_data_MEM   = out_data;
    assign bus.OUT_data64_MEM = out_data64;
    assign bus.WB_control_MEM = wb_ctrl;
    assign bus.Stall          = stall;
    assign bus.Fault          = fault;

endmodule
